// File: rtl/boron_sbox_layer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | boron_sbox_layer: time-shared BORON 4-bit S-box layer, LANES nibbles/clk |
// | Optional: BORON_SBOX_SELFCHECK_EN adds inverse-check logic and err_o.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module boron_sbox_layer #(
  parameter int DATA_W = 64,
  parameter int LANES  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] data_o,
`ifdef BORON_SBOX_SELFCHECK_EN
  output logic              err_o,
`endif
  output logic              busy_o
);

  localparam int NNIB  = DATA_W / 4;
  localparam int NSTEP = DATA_W / (4 * LANES);
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mode;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_sub;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [3:0]        w_lane_in  [LANES];
  logic [3:0]        w_lane_out [LANES];

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
      4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
      4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
      4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hA;  4'h1: y = 4'h3;  4'h2: y = 4'h9;  4'h3: y = 4'hE;
      4'h4: y = 4'h1;  4'h5: y = 4'hD;  4'h6: y = 4'hF;  4'h7: y = 4'h4;
      4'h8: y = 4'hC;  4'h9: y = 4'h5;  4'hA: y = 4'h7;  4'hB: y = 4'h2;
      4'hC: y = 4'h6;  4'hD: y = 4'h8;  4'hE: y = 4'h0;  default: y = 4'hB;
    endcase
    return y;
  endfunction

  assign w_last = (r_cnt == CNT_W'(NSTEP - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid_i) begin
          w_load      = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready_o  = (r_state == ST_IDLE);
  assign out_valid_o = (r_state == ST_DONE);
  assign busy_o      = (r_state == ST_BUSY) || (r_state == ST_DONE);
  assign data_o      = r_data;

  // Each lane l sees nibble (cnt*LANES + l); the mux is built from constant slices.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_in[l] = 4'h0;
      for (int s = 0; s < NSTEP; s++) begin
        if (r_cnt == CNT_W'(s)) begin
          w_lane_in[l] = r_data[(s*LANES + l)*4 +: 4];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_out[l] = r_mode ? sbox_inv(w_lane_in[l]) : sbox_fwd(w_lane_in[l]);
  end

  always_comb begin
    w_data_sub = r_data;
    for (int n = 0; n < NNIB; n++) begin
      if (r_cnt == CNT_W'(n / LANES)) begin
        w_data_sub[n*4 +: 4] = w_lane_out[n % LANES];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data <= '0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_data <= data_i;
      r_mode <= mode_i;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_data <= w_data_sub;
      // Hold on the final step so the counter never wraps.
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef BORON_SBOX_SELFCHECK_EN
  logic w_chk_fail;
  logic r_err;

  always_comb begin
    w_chk_fail = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if ((r_mode ? sbox_fwd(w_lane_out[l]) : sbox_inv(w_lane_out[l])) != w_lane_in[l]) begin
        w_chk_fail = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_BUSY) && w_chk_fail) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_boron_sbox_layer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_boron_sbox_layer: vector table, random round-trip and corner sequences|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_boron_sbox_layer;

  localparam int DATA_W = 64;
  localparam int LANES  = 4;
  localparam int NSTEP  = DATA_W / (4 * LANES);

  localparam logic [3:0] FWD [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                      4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  localparam logic [3:0] INV [16] = '{4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
                                      4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB};

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic              mode_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [DATA_W-1:0] data_o;
  logic              busy_o;
`ifdef BORON_SBOX_SELFCHECK_EN
  logic              err_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  boron_sbox_layer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .mode_i      (mode_i),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
`ifdef BORON_SBOX_SELFCHECK_EN
    .err_o       (err_o),
`endif
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] din;
    logic        mode;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [63:0] model(input logic [63:0] d, input logic m);
    logic [63:0] r;
    r = d;
    for (int i = 0; i < DATA_W / 4; i++) begin
      r[i*4 +: 4] = m ? INV[d[i*4 +: 4]] : FWD[d[i*4 +: 4]];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Present a block, then wait (bounded) for out_valid_o; optionally inject noise meanwhile.
  task automatic accept_and_wait(input logic [63:0] din, input logic m, input bit noisy,
                                 output int lat);
    int guard;
    guard = 0;
    while (!in_ready_o && guard < 100) begin
      @(posedge clk_i); #1;
      guard++;
    end
    in_valid_i = 1'b1;
    data_i     = din;
    mode_i     = m;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    lat = 0;
    while (!out_valid_o && lat < 100) begin
      if (noisy) begin
        data_i     = {$urandom, $urandom};
        mode_i     = 1'($urandom);
        in_valid_i = 1'($urandom);
      end
      @(posedge clk_i); #1;
      lat++;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic release_out();
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic run_block(input logic [63:0] din, input logic m, input bit noisy,
                           output logic [63:0] res, output int lat);
    accept_and_wait(din, m, noisy, lat);
    res = data_o;
    release_out();
  endtask

  initial begin
    logic [63:0] res, res2, d, held;
    int lat;

    vecs[0] = '{64'h0123456789ABCDEF, 1'b0, 64'hE4B179CAD20F8536};
    vecs[1] = '{64'hE4B179CAD20F8536, 1'b1, 64'h0123456789ABCDEF};
    vecs[2] = '{64'h0000000000000000, 1'b0, 64'hEEEEEEEEEEEEEEEE};
    vecs[3] = '{64'h0000000000000000, 1'b1, 64'hAAAAAAAAAAAAAAAA};
    vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h6666666666666666};
    vecs[5] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hBBBBBBBBBBBBBBBB};

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("reset_in_ready",  64'(in_ready_o),  64'd1);
    check("reset_out_valid", 64'(out_valid_o), 64'd0);
    check("reset_busy",      64'(busy_o),      64'd0);
    check("reset_data",      data_o,           64'd0);

    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i].din, vecs[i].mode, 1'b0, res, lat);
      check("vec_data",    res,      vecs[i].exp);
      check("vec_latency", 64'(lat), 64'(NSTEP));
    end

    // DONE held with out_ready_i low: output frozen, new requests ignored.
    accept_and_wait(64'h0123456789ABCDEF, 1'b0, 1'b1, lat);
    check("hold_latency", 64'(lat), 64'(NSTEP));
    held = data_o;
    check("hold_data0", held, 64'hE4B179CAD20F8536);
    for (int c = 0; c < 10; c++) begin
      in_valid_i = 1'($urandom);
      data_i     = {$urandom, $urandom};
      mode_i     = 1'($urandom);
      @(posedge clk_i); #1;
      check("hold_valid",    64'(out_valid_o), 64'd1);
      check("hold_in_ready", 64'(in_ready_o),  64'd0);
      check("hold_busy",     64'(busy_o),      64'd1);
      check("hold_data",     data_o,           held);
    end
    in_valid_i = 1'b0;
    release_out();
    check("after_release_ready", 64'(in_ready_o), 64'd1);

    // Reset with two steps done and the third about to happen.
    in_valid_i = 1'b1;
    data_i     = 64'h1122334455667788;
    mode_i     = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("midrst_in_ready",  64'(in_ready_o),  64'd1);
    check("midrst_out_valid", 64'(out_valid_o), 64'd0);
    check("midrst_busy",      64'(busy_o),      64'd0);
    check("midrst_data",      data_o,           64'd0);
    run_block(64'h0123456789ABCDEF, 1'b0, 1'b0, res, lat);
    check("midrst_next_data",    res,      64'hE4B179CAD20F8536);
    check("midrst_next_latency", 64'(lat), 64'(NSTEP));

    for (int i = 0; i < 200; i++) begin
      d = {$urandom, $urandom};
      run_block(d, 1'b0, 1'b1, res, lat);
      check("rand_enc", res, model(d, 1'b0));
      check("rand_enc_latency", 64'(lat), 64'(NSTEP));
      run_block(res, 1'b1, 1'b1, res2, lat);
      check("rand_roundtrip", res2, d);
    end

`ifdef BORON_SBOX_SELFCHECK_EN
    check("selfcheck_err", 64'(err_o), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
